// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store controller for a 32-bit word-addressed memory.
// Handles lw/lh/lb/sw/sh/sb, sub-word stores via read-modify-write of the containing word.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_RWAIT = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] OP_SW = 3'b100;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        acc_err;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;

    // Handshake: a request is taken only when start=1 in IDLE (busy=0); any start
    // seen while busy=1 is dropped. Completion is the single-cycle done pulse, with
    // err and rdata valid in that same cycle.
    assign accept = (state_q == S_IDLE) && start;

    // op[1:0]==11 is illegal; word needs addr[1:0]==0, half needs addr[0]==0.
    always_comb begin
        acc_err = 1'b0;
        case (op[1:0])
            2'b00:   acc_err = (addr[1:0] != 2'b00);
            2'b01:   acc_err = addr[0];
            2'b10:   acc_err = 1'b0;
            default: acc_err = 1'b1;
        endcase
    end

    assign byte_sh = {addr_q[1:0], 3'b000};
    assign half_sh = {addr_q[1], 4'b0000};

    always_comb begin
        load_val = mem_rdata;
        case (op_q[1:0])
            2'b01:   load_val = {16'h0000, mem_rdata[half_sh +: 16]};
            2'b10:   load_val = {24'h000000, mem_rdata[byte_sh +: 8]};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        merged = word_q;
        case (op_q[1:0])
            2'b01:   merged[half_sh +: 16] = wdata_q[15:0];
            2'b10:   merged[byte_sh +: 8]  = wdata_q[7:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = addr;
                    op_d    = op;
                    wdata_d = wdata;
                    err_d   = acc_err;
                    if (acc_err) begin
                        state_d = S_DONE;
                    end else if (op == OP_SW) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: state_d = S_RWAIT;
            S_RWAIT: begin
                word_d = mem_rdata;
                if (op_q[2]) begin
                    state_d = S_WR;
                end else begin
                    rdata_d = load_val;
                    state_d = S_DONE;
                end
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            op_q    <= 3'h0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = done && err_q;
    assign rdata     = rdata_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wr    = (state_q == S_WR);
    assign mem_wdata = merged;
    assign dbg_state = state_q;

    logic unused_accept;
    assign unused_accept = accept;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a memory model serves reads/writes, a scoreboard
// holds expected completions and writes, and monitors compare them as they appear.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] cyc = 16'h0;

    // {done_cycle[15:0], err, rdata[31:0]}
    logic [48:0] exp_q[$];
    // {write_cycle[15:0], word_addr[31:0], data[31:0]}
    logic [79:0] wr_q[$];

    logic [31:0] mem [0:63];
    logic        preload;

    mem_access_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / memory ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 16'd1;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[1]  <= 32'hCAFEF00D;
            mem[4]  <= 32'hDEADBEEF;
            mem[8]  <= 32'h8765ABCD;
            mem[63] <= 32'h0BADC0DE;
        end else if (mem_wr) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[7:2]];
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && !preload) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [48:0] e;
                    e = exp_q.pop_front();
                    check("done_cycle", {16'h0, cyc}, {16'h0, e[48:33]});
                    check("err", {31'h0, err}, {31'h0, e[32]});
                    check("rdata", rdata, e[31:0]);
                    check("busy_in_done", {31'h0, busy}, 32'd1);
                end
            end else begin
                check("err_without_done", {31'h0, err}, 32'd0);
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_mem_wr", 32'd1, 32'd0);
                end else begin
                    logic [79:0] w;
                    w = wr_q.pop_front();
                    check("wr_cycle", {16'h0, cyc}, {16'h0, w[79:64]});
                    check("wr_addr", mem_addr, w[63:32]);
                    check("wr_data", mem_wdata, w[31:0]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge; waits for IDLE, presents one request for one cycle.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                         input logic e_err, input logic [31:0] e_rd, input int lat,
                         input logic [31:0] e_wd);
        int waited;
        waited = 0;
        while (busy && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            check("idle_timeout", 32'd1, 32'd0);
            return;
        end
        start = 1'b1;
        op    = o;
        addr  = a;
        wdata = w;
        exp_q.push_back({cyc + 16'(lat), e_err, e_rd});
        if (o[2] && !e_err) wr_q.push_back({cyc + 16'(lat - 1), {a[31:2], 2'b00}, e_wd});
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        addr  = $urandom;
        wdata = $urandom;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while ((busy || exp_q.size() != 0) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("drain_timeout", {31'h0, busy}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        preload = 1'b1;
        start   = 1'b0;
        op      = 3'b000;
        addr    = 32'h0;
        wdata   = 32'h0;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        check("reset_busy", {31'h0, busy}, 32'd0);
        check("reset_done", {31'h0, done}, 32'd0);
        check("reset_mem_wr", {31'h0, mem_wr}, 32'd0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        //     op       addr           wdata          err   rdata          lat  mem_wdata
        issue(3'b000, 32'h0000_0010, 32'h0,          1'b0, 32'hDEADBEEF, 3, 32'h0);
        issue(3'b100, 32'h0000_0010, 32'h11223344,   1'b0, 32'hDEADBEEF, 2, 32'h11223344);
        issue(3'b110, 32'h0000_0013, 32'h000000AA,   1'b0, 32'hDEADBEEF, 4, 32'hAA223344);
        issue(3'b000, 32'h0000_0010, 32'h0,          1'b0, 32'hAA223344, 3, 32'h0);
        issue(3'b001, 32'h0000_0022, 32'h0,          1'b0, 32'h00008765, 3, 32'h0);
        issue(3'b010, 32'h0000_0021, 32'h0,          1'b0, 32'h000000AB, 3, 32'h0);
        issue(3'b000, 32'h0000_0006, 32'h0,          1'b1, 32'h000000AB, 1, 32'h0);
        issue(3'b011, 32'h0000_0010, 32'h0,          1'b1, 32'h000000AB, 1, 32'h0);
        issue(3'b111, 32'h0000_0010, 32'hFFFFFFFF,   1'b1, 32'h000000AB, 1, 32'h0);
        issue(3'b001, 32'h0000_0023, 32'h0,          1'b1, 32'h000000AB, 1, 32'h0);
        issue(3'b101, 32'h0000_0021, 32'h0000BEEF,   1'b1, 32'h000000AB, 1, 32'h0);
        issue(3'b100, 32'h0000_0012, 32'h55555555,   1'b1, 32'h000000AB, 1, 32'h0);
        issue(3'b101, 32'h0000_0022, 32'h12345678,   1'b0, 32'h000000AB, 4, 32'h5678ABCD);
        issue(3'b010, 32'h0000_0020, 32'h0,          1'b0, 32'h000000CD, 3, 32'h0);
        issue(3'b010, 32'h0000_0023, 32'h0,          1'b0, 32'h00000056, 3, 32'h0);
        issue(3'b001, 32'h0000_0020, 32'h0,          1'b0, 32'h0000ABCD, 3, 32'h0);
        issue(3'b000, 32'h0000_0020, 32'h0,          1'b0, 32'h5678ABCD, 3, 32'h0);
        issue(3'b000, 32'hFFFF_FFFC, 32'h0,          1'b0, 32'h0BADC0DE, 3, 32'h0);
        issue(3'b110, 32'hFFFF_FFFC, 32'h00000011,   1'b0, 32'h0BADC0DE, 4, 32'h0BADC011);
        issue(3'b001, 32'hFFFF_FFFE, 32'h0,          1'b0, 32'h00000BAD, 3, 32'h0);
        issue(3'b010, 32'hFFFF_FFFD, 32'h0,          1'b0, 32'h000000C0, 3, 32'h0);
        wait_idle();

        // sh aborted by reset in RWAIT, with a start pulse ignored while busy
        start = 1'b1; op = 3'b101; addr = 32'h4; wdata = 32'h00005555;
        @(negedge clk);
        start = 1'b1; op = 3'b000; addr = 32'h10;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_mem_wr", {31'h0, mem_wr}, 32'd0);
        check("abort_rdata", rdata, 32'h0);
        check("abort_mem_addr", mem_addr, 32'h0);
        check("abort_mem_wdata", mem_wdata, 32'h0);
        repeat (4) @(negedge clk);
        check("abort_mem_word", mem[1], 32'hCAFEF00D);

        // reset wins over start in the same cycle
        reset = 1'b1; start = 1'b1; op = 3'b000; addr = 32'h10;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("reset_priority_busy", {31'h0, busy}, 32'd0);
        @(negedge clk);
        check("reset_priority_idle", {31'h0, busy}, 32'd0);

        issue(3'b000, 32'h0000_0004, 32'h0,          1'b0, 32'hCAFEF00D, 3, 32'h0);
        wait_idle();
        repeat (3) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("wr_q_empty", wr_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters: none; all widths fixed (32-bit address and data, 3-bit op).
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request strobe, sampled only in IDLE.
REQ-005 op  input  3  000 lw, 001 lh, 010 lb, 100 sw, 101 sh, 110 sb; 011/111 illegal.
REQ-006 addr  input  32  byte address from the IorD address-select path.
REQ-007 wdata  input  32  store data; sh uses [15:0], sb uses [7:0].
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 err  output  1  valid with done; 1 = misaligned or illegal op.
REQ-011 rdata  output  32  load result, zero-extended for lh/lb, held until next load completes.
REQ-012 mem_addr  output  32  word address to memory, always {addr_q[31:2],2'b00}.
REQ-013 mem_wr  output  1  memory write enable, one cycle per store.
REQ-014 mem_wdata  output  32  word written to memory.
REQ-015 mem_rdata  input  32  memory read data, valid the cycle after mem_addr presented with mem_wr=0.

Function
REQ-016 States: IDLE, RD, RWAIT, WR, DONE; encoding free.
REQ-017 IDLE with start=1: latch addr, op, wdata into addr_q, op_q, wdata_q; later input changes have no effect.
REQ-018 Accept-time checks: illegal op, or lw/sw with addr[1:0]!=0, or lh/sh with addr[0]!=0 -> DONE with err=1, no memory access.
REQ-019 Legal lw/lh/lb/sh/sb -> RD; legal sw -> WR.
REQ-020 RD: mem_addr driven, mem_wr=0; next state RWAIT.
REQ-021 RWAIT: capture mem_rdata into word register at cycle end; loads -> DONE, sh/sb -> WR.
REQ-022 WR: mem_wr=1 exactly this cycle; sw writes wdata_q; sh/sb write captured word with target lane replaced (read-modify-write); next state DONE.
REQ-023 Lanes little-endian: byte k=addr_q[1:0] occupies bits [8k+7:8k]; half at addr_q[1] occupies bits [16*addr_q[1]+15:16*addr_q[1]].
REQ-024 Loads: rdata updated on entering DONE; lw full word, lh selected half, lb selected byte, upper bits 0.
REQ-025 DONE: done=1, err as determined; unconditional return to IDLE next cycle.
REQ-026 Latency from accept cycle (cycle 0): loads done cycle 3; sw done cycle 2; sh/sb done cycle 4; errors done cycle 1.
REQ-027 start while busy=1 (including DONE) ignored, not queued; back-to-back requests need start in IDLE.
REQ-028 mem_wr=0 in every state except WR; mem_addr holds last value in IDLE.
REQ-029 err=0 whenever done=0; rdata unchanged on stores and on error completions.
REQ-030 Address wrap: none; addr 0xFFFFFFFC is a legal word access.

Reset
REQ-031 reset=1 at a rising edge forces IDLE; busy, done, err, mem_wr=0; rdata, mem_addr, mem_wdata, latched registers=0.
REQ-032 Reset mid-operation aborts; no mem_wr pulse in the cycle following the reset edge; partial RMW never written.
REQ-033 reset has priority over start in the same cycle.

Verification
REQ-034 lw addr=0x00000010, memory word 0xDEADBEEF -> mem_addr 0x10 in cycle 1, done cycle 3, rdata=0xDEADBEEF, err=0.
REQ-035 sb addr=0x00000013, wdata=0x000000AA, memory word 0x11223344 -> single mem_wr in cycle 3, mem_wdata=0xAA223344, done cycle 4.
REQ-036 lh addr=0x00000022, memory word 0x8765ABCD -> rdata=0x00008765; then lb addr=0x00000021 -> rdata=0x000000AB.
REQ-037 lw addr=0x00000006 and op=011 -> done cycle 1, err=1, mem_wr never asserted, rdata unchanged.
REQ-038 sh addr=0x4 with reset asserted in RWAIT -> IDLE next cycle, mem_wr stays 0, memory word unchanged; start pulsed during busy ignored.
